// File: rtl/sap_ram_param.sv
// SAP program/data RAM with memory address register, post-reset zero-fill sweep,
// and a synchronised manual program-write button with optional auto-increment pointer.
module sap_ram_param #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AUTO_INC    = 1
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  prog_mode,
   input  logic [DATA_WIDTH-1:0] dipswitch_data,
   input  logic [ADDR_WIDTH-1:0] dipswitch_addr,
   input  logic                  prog_write_n,
   input  logic [DATA_WIDTH-1:0] bus_in,
   input  logic                  load_addr_reg,
   input  logic                  write_enable,
   input  logic                  output_enable,
   output logic [DATA_WIDTH-1:0] bus_out,
   output logic [ADDR_WIDTH-1:0] mar_out,
   output logic                  busy,
   output logic                  prog_ack
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PROG = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  sweep_q, sweep_d;
   logic [ADDR_WIDTH-1:0]  mar_q, mar_d;
   logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
   logic [SYNC_STAGES-1:0] mode_sync_q;
   logic [SYNC_STAGES-1:0] wr_sync_q;
   logic                   wr_prev_q;
   logic                   ack_q, ack_d;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic                   mem_we;
   logic [ADDR_WIDTH-1:0]  mem_waddr;
   logic [DATA_WIDTH-1:0]  mem_wdata;

   logic                   mode_s;
   logic                   wr_fall;
   logic [ADDR_WIDTH-1:0]  eff_addr;

   assign mode_s   = mode_sync_q[SYNC_STAGES-1];
   assign wr_fall  = !wr_sync_q[SYNC_STAGES-1] && wr_prev_q;
   assign eff_addr = (AUTO_INC != 0) ? ptr_q : dipswitch_addr;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      sweep_d   = sweep_q;
      mar_d     = mar_q;
      ptr_d     = ptr_q;
      ack_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = sweep_q;
      mem_wdata = '0;
      case (state_q)
         ST_INIT: begin
            mem_we  = 1'b1;
            sweep_d = sweep_q + ADDR_ONE;
            if (sweep_q == LAST_ADDR) state_d = mode_s ? ST_RUN : ST_PROG;
         end
         ST_RUN: begin
            // The write address is the pre-load MAR, even when a load lands on the same edge.
            if (write_enable) begin
               mem_we    = 1'b1;
               mem_waddr = mar_q;
               mem_wdata = bus_in;
            end
            if (load_addr_reg) mar_d = bus_in[ADDR_WIDTH-1:0];
            if (!mode_s) begin
               state_d = ST_PROG;
               if (AUTO_INC != 0) ptr_d = dipswitch_addr;
            end
         end
         ST_PROG: begin
            if (wr_fall) begin
               mem_we    = 1'b1;
               mem_waddr = eff_addr;
               mem_wdata = dipswitch_data;
               ack_d     = 1'b1;
               if (AUTO_INC != 0) ptr_d = ptr_q + ADDR_ONE;
            end
            if ((AUTO_INC != 0) && load_addr_reg) ptr_d = dipswitch_addr;
            if (mode_s) state_d = ST_RUN;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (clear) begin
         state_q     <= ST_INIT;
         sweep_q     <= '0;
         mar_q       <= '0;
         ptr_q       <= '0;
         mode_sync_q <= '1;
         wr_sync_q   <= '1;
         wr_prev_q   <= 1'b1;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         mar_q       <= mar_d;
         ptr_q       <= ptr_d;
         mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], prog_mode};
         wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], prog_write_n};
         wr_prev_q   <= wr_sync_q[SYNC_STAGES-1];
         ack_q       <= ack_d;
      end
   end

   // NOTE: the memory array has no reset; the INIT sweep zero-fills it instead.
   always_ff @(posedge clk) begin
      if (mem_we && !clear) mem_q[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      case (state_q)
         ST_RUN:  mar_out = mar_q;
         ST_PROG: mar_out = eff_addr;
         default: mar_out = '0;
      endcase
   end

   assign bus_out  = ((state_q == ST_RUN) && output_enable) ? mem_q[mar_q] : '0;
   assign busy     = (state_q == ST_INIT);
   assign prog_ack = ack_q;

endmodule

// File: tb/tb_sap_ram_param.sv
// Scoreboard bench for sap_ram_param: a bench-side memory model predicts every read,
// expected words are queued at stimulus time and popped when bus_out is sampled.
module tb_sap_ram_param;

   logic       clk = 1'b0;
   logic       clear;
   logic       prog_mode;
   logic [7:0] dipswitch_data;
   logic [3:0] dipswitch_addr;
   logic       prog_write_n;
   logic [7:0] bus_in;
   logic       load_addr_reg;
   logic       write_enable;
   logic       output_enable;
   logic [7:0] bus_out;
   logic [3:0] mar_out;
   logic       busy;
   logic       prog_ack;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] model [16];
   logic [7:0] exp_q [$];

   sap_ram_param dut (
      .clk            (clk),
      .clear          (clear),
      .prog_mode      (prog_mode),
      .dipswitch_data (dipswitch_data),
      .dipswitch_addr (dipswitch_addr),
      .prog_write_n   (prog_write_n),
      .bus_in         (bus_in),
      .load_addr_reg  (load_addr_reg),
      .write_enable   (write_enable),
      .output_enable  (output_enable),
      .bus_out        (bus_out),
      .mar_out        (mar_out),
      .busy           (busy),
      .prog_ack       (prog_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sweep(input string tag);
      int n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      check(tag, n, 16);
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
   endtask

   task automatic rd(input logic [3:0] a);
      bus_in        = {4'h0, a};
      load_addr_reg = 1'b1;
      tick();
      load_addr_reg = 1'b0;
      output_enable = 1'b1;
      exp_q.push_back(model[a]);
      #1;
      check($sformatf("rd_mar_%0h", a), mar_out, a);
      if (exp_q.size() > 0) check($sformatf("rd_data_%0h", a), bus_out, exp_q.pop_front());
      output_enable = 1'b0;
   endtask

   task automatic run_write(input logic [3:0] a, input logic [7:0] d);
      bus_in        = {4'h0, a};
      load_addr_reg = 1'b1;
      tick();
      load_addr_reg = 1'b0;
      bus_in        = d;
      write_enable  = 1'b1;
      tick();
      write_enable  = 1'b0;
      model[a]      = d;
   endtask

   task automatic press(input logic [7:0] d, input logic [3:0] exp_ptr);
      int lat = 0;
      dipswitch_data = d;
      prog_write_n   = 1'b0;
      while (!prog_ack && lat < 10) begin
         tick();
         lat++;
      end
      check("press_latency", lat, 3);
      check("press_ptr", mar_out, exp_ptr);
      tick();
      check("ack_single", prog_ack, 1'b0);
      prog_write_n = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      int acks;
      clear = 1'b1; prog_mode = 1'b1; prog_write_n = 1'b1;
      dipswitch_data = '0; dipswitch_addr = '0; bus_in = '0;
      load_addr_reg = 1'b0; write_enable = 1'b0; output_enable = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;

      // Reset values
      tick(); tick();
      check("rst_busy", busy, 1'b1);
      check("rst_ack", prog_ack, 1'b0);
      check("rst_bus", bus_out, 8'h00);
      check("rst_mar", mar_out, 4'h0);
      clear = 1'b0;
      wait_sweep("sweep_len");
      for (int a = 0; a < 16; a++) rd(4'(a));

      // RUN write / read
      run_write(4'h5, 8'hA7);
      rd(4'h5);
      #1 check("oe_off_bus", bus_out, 8'h00);

      // Enter PROG; bus writes and reads are suppressed
      prog_mode = 1'b0;
      repeat (4) tick();
      bus_in = 8'h55; write_enable = 1'b1; output_enable = 1'b1;
      #1 check("prog_bus_zero", bus_out, 8'h00);
      check("prog_not_busy", busy, 1'b0);
      tick();
      write_enable = 1'b0; output_enable = 1'b0;

      dipswitch_addr = 4'hF; load_addr_reg = 1'b1;
      tick();
      load_addr_reg = 1'b0;
      check("ptr_load", mar_out, 4'hF);
      press(8'hCF, 4'h0);
      model[15] = 8'hCF;
      press(8'h11, 4'h1);
      model[0] = 8'h11;

      // Held button gives a single write
      dipswitch_data = 8'h3C;
      prog_write_n   = 1'b0;
      acks = 0;
      repeat (20) begin
         tick();
         if (prog_ack) acks++;
      end
      check("hold_acks", acks, 1);
      model[1] = 8'h3C;
      prog_write_n = 1'b1;
      repeat (3) tick();
      check("hold_ptr", mar_out, 4'h2);

      // Back to RUN: MAR retained, manual writes visible
      prog_mode = 1'b1;
      repeat (4) tick();
      check("run_mar_kept", mar_out, 4'h5);
      rd(4'hF); rd(4'h0); rd(4'h1); rd(4'h5);

      // Simultaneous load and write use the pre-load MAR
      bus_in = 8'h03; load_addr_reg = 1'b1;
      tick();
      bus_in = 8'h09; write_enable = 1'b1;
      tick();
      load_addr_reg = 1'b0; write_enable = 1'b0;
      model[3] = 8'h09;
      check("ldwr_mar", mar_out, 4'h9);
      rd(4'h3); rd(4'h9);

      // Clear mid-sweep restarts the fill
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (7) tick();
      clear = 1'b1;
      #1 check("mid_clear_busy", busy, 1'b1);
      tick();
      clear = 1'b0;
      wait_sweep("resweep_len");
      for (int a = 0; a < 16; a++) rd(4'(a));

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sap_ram_param.md
Name: sap_ram_param

Overview:
- Parametrised successor to the SAP program/data RAM with its memory address register (MAR).
- Adds configurable data/address width and a post-reset zero-fill sweep.
- Adds a synchronised, edge-detected manual program-write button with an optional auto-incrementing program pointer.
- Sits on the 8-bit SAP bus: the MAR loads from the bus in run mode; the operator loads RAM from dipswitches in program mode.

Parameters:
- DATA_WIDTH, 8: memory word width and bus width.
- ADDR_WIDTH, 4: MAR width; DEPTH = 2**ADDR_WIDTH words.
- SYNC_STAGES, 2: flops in each synchroniser (prog_write_n, prog_mode); legal range 2..4.
- AUTO_INC, 1: 1 = program pointer increments after each manual write; 0 = program address is taken directly from dipswitch_addr.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- prog_mode  in  1  asynchronous; 0 = program mode (dipswitches), 1 = run mode (bus).
- dipswitch_data  in  DATA_WIDTH  manual write data.
- dipswitch_addr  in  ADDR_WIDTH  manual address.
- prog_write_n  in  1  asynchronous manual write button, active low.
- bus_in  in  DATA_WIDTH  bus data; low ADDR_WIDTH bits are the MAR load value.
- load_addr_reg  in  1  synchronous, active high. Run mode: MAR <= bus_in. Program mode with AUTO_INC=1: pointer <= dipswitch_addr.
- write_enable  in  1  synchronous, active high; run-mode write of bus_in to mem[MAR].
- output_enable  in  1  drives bus_out in run mode.
- bus_out  out  DATA_WIDTH  mem[MAR] when enabled, else 0.
- mar_out  out  ADDR_WIDTH  current effective address.
- busy  out  1  zero-fill sweep in progress.
- prog_ack  out  1  one-cycle pulse after a committed manual write.

Behaviour:
- Clear (asynchronous, active high) sets:
  - FSM to INIT, sweep counter = 0, MAR = 0, program pointer = 0.
  - prog_write_n synchroniser chain and edge-detect flop to 1.
  - prog_mode synchroniser to 1.
  - Outputs: busy = 1, prog_ack = 0, bus_out = 0, mar_out = 0.
  - Memory contents are not touched by clear itself.
- FSM states: INIT, RUN, PROG.
- INIT:
  - Each cycle writes 0 to mem[sweep counter], then increments the counter.
  - After writing address DEPTH-1, goes to RUN if synced prog_mode = 1, else PROG.
  - busy = 1 for exactly DEPTH cycles after clear deasserts.
  - All writes and loads are ignored; bus_out = 0.
  - Clear asserted mid-sweep restarts the sweep from address 0.
- RUN (synced prog_mode = 1):
  - mar_out = MAR.
  - load_addr_reg: MAR <= bus_in[ADDR_WIDTH-1:0] at the edge.
  - write_enable: mem[MAR] <= bus_in at the edge.
  - load_addr_reg and write_enable in the same cycle: the write uses the pre-load MAR, and MAR updates at the same edge.
  - bus_out = output_enable ? mem[MAR] : 0. The read is combinational from MAR (zero-latency, 74189 style).
  - prog_write_n edges are ignored.
  - Synced prog_mode = 0 goes to PROG. On entry with AUTO_INC=1, pointer <= dipswitch_addr.
- PROG (synced prog_mode = 0):
  - bus_out = 0; write_enable and bus_in are ignored.
  - Effective address: AUTO_INC=1 uses the pointer; AUTO_INC=0 uses dipswitch_addr. mar_out shows it.
  - Manual write detection: falling edge of synced prog_write_n (synced value 0, previous synced value 1).
  - Button first sampled low at edge 1: the write of dipswitch_data to mem[effective address] occurs at edge SYNC_STAGES+1. prog_ack = 1 for the following cycle only.
  - A button held low gives exactly one write; it must be seen high before the next write.
  - AUTO_INC=1: pointer increments at the write edge, wrapping DEPTH-1 -> 0.
  - load_addr_reg in the same cycle as a write edge: the write uses the old pointer, and the load wins over the increment.
  - Synced prog_mode = 1 goes to RUN; MAR keeps its last RUN value.
- The prog_mode synchroniser adds SYNC_STAGES cycles of mode-change latency.
- Out-of-range addresses cannot occur: all address arithmetic is modulo DEPTH.

Test Plan:
- Defaults; pulse clear, release -> busy = 1 for exactly 16 cycles; a run-mode read of each address 0..15 then returns 0x00.
- RUN: bus_in = 0x05 with load_addr_reg; then bus_in = 0xA7 with write_enable; then output_enable -> mar_out = 5, bus_out = 0xA7. With output_enable = 0 -> bus_out = 0.
- PROG, AUTO_INC=1:
  - dipswitch_addr = 0xF, pulse load_addr_reg.
  - Press prog_write_n twice (released between), dipswitch_data = 0xCF then 0x11.
  - Expect mem[15] = 0xCF, mem[0] = 0x11, pointer wrapped to 1, two single-cycle prog_ack pulses, each 3 edges after the press.
- PROG: hold prog_write_n low for 20 cycles -> exactly one write and one prog_ack.
- RUN: MAR = 3, bus_in = 0x09 with load_addr_reg and write_enable together -> mem[3] = 0x09, MAR = 9, mem[9] unchanged.
- Assert clear at sweep cycle 7, release -> busy lasts a further 16 cycles; earlier written data in addresses 0..15 reads 0.
